dsky_serial_ingest: RTL and testbench

//  - Receives bytes from uart_rx, parses fixed 5-byte frames and writes six 15-bit input registers.
//  - The six registers are VERB, NOUN, AXI_G, AXI_RA, AXI_RB and AXI_ATX.
//  - Its outputs drive the data_DSKY_* and data_AXI_* inputs of IO_register_file; the core reads them via IO_read_sel.
//  - Returns a one-byte ACK/NAK per frame through a uart_tx-style start/busy handshake.

---
 rtl/agc_serial_pkg.sv | 13 +
 rtl/ingest_timeout_ctr.sv | 19 +
 rtl/dsky_serial_ingest.sv | 116 +++++++++++
 tb/tb_dsky_serial_ingest.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_serial_pkg.sv
// agc_serial_pkg: shared types and constants for the DSKY/AXI serial ingest path
package agc_serial_pkg;
   typedef enum logic [2:0] {IDLE, GET_ID, GET_HI, GET_LO, GET_CHK, COMMIT} ingest_state_t;
   localparam logic [2:0] REG_VERB = 3'd0;
   localparam logic [2:0] REG_NOUN = 3'd1;
   localparam logic [2:0] REG_G    = 3'd2;
   localparam logic [2:0] REG_RA   = 3'd3;
   localparam logic [2:0] REG_RB   = 3'd4;
   localparam logic [2:0] REG_ATX  = 3'd5;
   localparam logic [7:0] ACK_OK  = 8'h5A;
   localparam logic [7:0] ACK_NAK = 8'hEE;
   localparam int NUM_IO_IN_REGS = 6;
endpackage

// File: rtl/ingest_timeout_ctr.sv
// ingest_timeout_ctr: reloadable down-counter, expire is high while the count sits at zero
module ingest_timeout_ctr #(
   parameter int unsigned LOAD = 99999
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int W = (LOAD > 1) ? $clog2(LOAD + 1) : 1;
   logic [W-1:0] cnt;
   // reload on clear, otherwise count down and park at zero
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= W'(LOAD);
      else if (clear) cnt <= W'(LOAD);
      else if (enable && cnt != '0) cnt <= cnt - 1'b1;
   assign expire = (cnt == '0);
endmodule

// File: rtl/dsky_serial_ingest.sv
// dsky_serial_ingest: parses SYNC/ID/HI/LO/CHK frames into six 15-bit input registers with ACK/NAK reply
module dsky_serial_ingest
   import agc_serial_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter bit          ACK_EN         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [14:0] verb_data,
   output logic [14:0] noun_data,
   output logic [14:0] axi_g_data,
   output logic [14:0] axi_ra_data,
   output logic [14:0] axi_rb_data,
   output logic [14:0] axi_atx_data,
   output logic        update_valid,
   output logic [2:0]  update_sel,
   output logic [7:0]  frame_err_count
);
   ingest_state_t state, state_nx;
   logic [2:0]  id_q;
   logic [6:0]  hi_q;
   logic [7:0]  lo_q;
   logic [14:0] regs [NUM_IO_IN_REGS];
   logic        frame_err, commit_wr, tmo_expire, tmo_en, tmo;
   logic        pending, start_q, queue;
   logic [7:0]  code;

   assign tmo_en = (state != IDLE) && (state != COMMIT);
   assign tmo    = tmo_expire && tmo_en && !rx_valid;

   ingest_timeout_ctr #(.LOAD(TIMEOUT_CYCLES - 1)) u_tmo (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (rx_valid || state == IDLE),
      .enable  (tmo_en),
      .expire  (tmo_expire)
   );

   // frame FSM state register
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   // next-state and error decode; a received byte always beats a same-cycle timeout
   always_comb begin
      state_nx  = state;
      frame_err = 1'b0;
      case (state)
         IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_nx = GET_ID;
         GET_ID:  if (rx_valid) {state_nx, frame_err} = (rx_data > 8'(NUM_IO_IN_REGS - 1)) ? {IDLE, 1'b1} : {GET_HI, 1'b0};
         GET_HI:  if (rx_valid) {state_nx, frame_err} = rx_data[7] ? {IDLE, 1'b1} : {GET_LO, 1'b0};
         GET_LO:  if (rx_valid) state_nx = GET_CHK;
         GET_CHK: if (rx_valid) {state_nx, frame_err} = (rx_data == ({5'd0, id_q} ^ {1'b0, hi_q} ^ lo_q)) ? {COMMIT, 1'b0} : {IDLE, 1'b1};
         default: state_nx = IDLE;
      endcase
      if (tmo) begin
         state_nx  = IDLE;
         frame_err = 1'b1;
      end
   end

   assign commit_wr    = (state == GET_CHK) && (state_nx == COMMIT);
   assign update_valid = (state == COMMIT);
   assign update_sel   = update_valid ? id_q : 3'd0;

   // field capture and register bank; the write lands on the CHK edge so the value is visible in COMMIT
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         id_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         for (int i = 0; i < NUM_IO_IN_REGS; i++) regs[i] <= '0;
      end else begin
         if (state == GET_ID && rx_valid) id_q <= rx_data[2:0];
         if (state == GET_HI && rx_valid) hi_q <= rx_data[6:0];
         if (state == GET_LO && rx_valid) lo_q <= rx_data;
         if (commit_wr) regs[id_q] <= {hi_q, lo_q};
      end

   assign verb_data    = regs[REG_VERB];
   assign noun_data    = regs[REG_NOUN];
   assign axi_g_data   = regs[REG_G];
   assign axi_ra_data  = regs[REG_RA];
   assign axi_rb_data  = regs[REG_RB];
   assign axi_atx_data = regs[REG_ATX];

   // saturating rejected-frame counter
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) frame_err_count <= '0;
      else if (frame_err && frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 1'b1;

   assign queue    = ACK_EN && (frame_err || state == COMMIT);
   assign tx_start = pending && !tx_busy && !start_q;
   assign tx_data  = code;

   // single-slot reply: newest code overwrites, start_q forces a gap so uart_tx can raise busy
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         pending <= 1'b0;
         start_q <= 1'b0;
         code    <= 8'h00;
      end else begin
         start_q <= tx_start;
         if (queue) begin
            pending <= 1'b1;
            code    <= frame_err ? ACK_NAK : ACK_OK;
         end else if (tx_start) pending <= 1'b0;
      end
endmodule

// File: tb/tb_dsky_serial_ingest.sv
// tb_dsky_serial_ingest: randomized and directed frame stimulus against a frame-level reference model
module tb_dsky_serial_ingest;
   localparam int T = 40;
   logic        clk, reset_n, rx_valid, tx_start, tx_busy, update_valid;
   logic [7:0]  rx_data, tx_data, frame_err_count;
   logic [14:0] verb_data, noun_data, axi_g_data, axi_ra_data, axi_rb_data, axi_atx_data;
   logic [2:0]  update_sel;
   logic [14:0] dut_regs [6];
   logic [14:0] m_regs [6];
   int          m_err;
   int          n_chk, n_fail;
   logic [7:0]  tx_log [$];
   logic [2:0]  upd_log [$];
   logic        prev_start, prev_upd;
   logic [7:0]  prev_err;

   dsky_serial_ingest #(.TIMEOUT_CYCLES(T)) dut (
      .clock(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .verb_data(verb_data), .noun_data(noun_data), .axi_g_data(axi_g_data),
      .axi_ra_data(axi_ra_data), .axi_rb_data(axi_rb_data), .axi_atx_data(axi_atx_data),
      .update_valid(update_valid), .update_sel(update_sel), .frame_err_count(frame_err_count)
   );

   assign dut_regs[0] = verb_data;
   assign dut_regs[1] = noun_data;
   assign dut_regs[2] = axi_g_data;
   assign dut_regs[3] = axi_ra_data;
   assign dut_regs[4] = axi_rb_data;
   assign dut_regs[5] = axi_atx_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor: log replies and updates, check pulse shape and counter stepping
   initial begin
      prev_start = 0;
      prev_upd = 0;
      prev_err = 0;
      forever begin
         @(negedge clk);
         #1;
         if (tx_start) begin
            tx_log.push_back(tx_data);
            check("tx_not_busy", tx_busy, 0);
            check("tx_gap", prev_start, 0);
         end
         if (update_valid) begin
            upd_log.push_back(update_sel);
            check("upd_pulse", prev_upd, 0);
         end
         if (reset_n && frame_err_count != prev_err) check("err_step", frame_err_count, prev_err + 8'd1);
         prev_start = tx_start;
         prev_upd = update_valid;
         prev_err = frame_err_count;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   task automatic model_frame(input logic [7:0] id, hi, lo, ck, output bit ok);
      ok = id <= 5 && !hi[7] && ck == (id ^ hi ^ lo);
      if (ok) m_regs[id] = {hi[6:0], lo};
      else if (m_err < 255) m_err++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_regs[i] = '0;
      m_err = 0;
   endtask

   task automatic post_check(input bit ok, input logic [7:0] id);
      repeat (5) @(negedge clk);
      check("upd_cnt", upd_log.size(), ok);
      if (ok && upd_log.size() > 0) check("upd_sel", upd_log[0], id);
      check("tx_cnt", tx_log.size(), 1);
      if (tx_log.size() > 0) check("tx_code", tx_log[0], ok ? 8'h5A : 8'hEE);
      check("err_cnt", frame_err_count, m_err);
      for (int i = 0; i < 6; i++) check($sformatf("reg%0d", i), dut_regs[i], m_regs[i]);
      tx_log.delete();
      upd_log.delete();
   endtask

   task automatic send_frame(input logic [7:0] id, hi, lo, ck);
      bit ok;
      send_byte(8'hA5);
      send_byte(id);
      if (id <= 5) begin
         send_byte(hi);
         if (!hi[7]) begin
            send_byte(lo);
            send_byte(ck);
         end
      end
      model_frame(id, hi, lo, ck, ok);
      post_check(ok, id);
   endtask

   initial begin
      bit ok;
      logic [7:0] id, hi, lo, ck;
      n_chk = 0;
      n_fail = 0;
      reset_n = 0;
      rx_valid = 0;
      rx_data = 0;
      tx_busy = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) check($sformatf("rst_reg%0d", i), dut_regs[i], 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_err", frame_err_count, 0);
      check("rst_upd", update_valid, 0);

      // VERB frame with latency check on the COMMIT cycle
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h37);
      @(negedge clk);
      rx_data = 8'h37;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      check("lat_verb", verb_data, 15'h0037);
      check("lat_upd", update_valid, 1);
      check("lat_sel", update_sel, 0);
      model_frame(8'h00, 8'h00, 8'h37, 8'h37, ok);
      post_check(ok, 8'h00);

      send_frame(8'h05, 8'h0A, 8'hBC, 8'hB3);
      check("atx_val", axi_atx_data, 15'h0ABC);
      send_frame(8'h01, 8'h00, 8'h05, 8'h04);
      check("noun_val", noun_data, 15'h0005);
      send_frame(8'h02, 8'h01, 8'h23, 8'h00);
      check("badchk_err", frame_err_count, 1);
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);
      check("badid_err", frame_err_count, 2);
      send_frame(8'h00, 8'h81, 8'h00, 8'h81);
      check("badhi_err", frame_err_count, 3);

      // silence after ID: no error one cycle early, error exactly at the limit
      send_byte(8'hA5);
      @(negedge clk);
      rx_data = 8'h03;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      repeat (T - 1) @(negedge clk);
      check("tmo_early", frame_err_count, m_err);
      @(negedge clk);
      check("tmo_fire", frame_err_count, m_err + 1);
      m_err++;
      post_check(0, 8'h03);
      send_frame(8'h03, 8'h2B, 8'hCD, 8'h2B ^ 8'hCD ^ 8'h03);

      // byte arriving in the expiry cycle keeps the frame alive
      send_byte(8'hA5);
      @(negedge clk);
      rx_data = 8'h02;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      repeat (T - 1) @(negedge clk);
      rx_data = 8'h12;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      send_byte(8'h34);
      send_byte(8'h24);
      model_frame(8'h02, 8'h12, 8'h34, 8'h24, ok);
      check("tmo_win_ok", ok, 1);
      post_check(ok, 8'h02);

      // two replies while busy: only the newest goes out once busy drops
      @(negedge clk);
      tx_busy = 1;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      model_frame(8'h00, 8'h01, 8'h02, 8'h03, ok);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
      model_frame(8'h01, 8'h00, 8'h00, 8'hFF, ok);
      repeat (5) @(negedge clk);
      check("busy_hold", tx_log.size(), 0);
      tx_busy = 0;
      repeat (5) @(negedge clk);
      check("busy_cnt", tx_log.size(), 1);
      if (tx_log.size() > 0) check("busy_code", tx_log[0], 8'hEE);
      check("busy_upd", upd_log.size(), 1);
      check("busy_err", frame_err_count, m_err);
      for (int i = 0; i < 6; i++) check($sformatf("busy_reg%0d", i), dut_regs[i], m_regs[i]);
      tx_log.delete();
      upd_log.delete();

      // randomized frames with occasional bad id, bad hi and corrupted checksum
      for (int n = 0; n < 40; n++) begin
         id = 8'($urandom_range(0, 7));
         hi = 8'($urandom_range(0, 255));
         hi[7] = ($urandom_range(0, 3) == 0);
         lo = 8'($urandom_range(0, 255));
         ck = id ^ hi ^ lo;
         if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
         send_frame(id, hi, lo, ck);
      end

      // reset in the middle of a frame
      send_byte(8'hA5);
      send_byte(8'h03);
      reset_n = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) check($sformatf("mid_rst_reg%0d", i), dut_regs[i], 0);
      check("mid_rst_err", frame_err_count, 0);
      check("mid_rst_tx", tx_start, 0);
      model_reset();
      reset_n = 1;
      tx_log.delete();
      upd_log.delete();
      send_frame(8'h04, 8'h7F, 8'hFF, 8'h04 ^ 8'h7F ^ 8'hFF);

      // drive the error counter into saturation
      for (int n = 0; n < 260; n++) begin
         send_byte(8'hA5);
         send_byte(8'h06);
         model_frame(8'h06, 8'h00, 8'h00, 8'h00, ok);
      end
      repeat (5) @(negedge clk);
      check("err_sat", frame_err_count, 8'hFF);
      tx_log.delete();
      upd_log.delete();
      send_frame(8'h07, 8'h00, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
